// File: rtl/mini_cpu_loader_if.sv
// mini_cpu_loader_if: valid/ready byte stream feeding the loader
interface mini_cpu_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    modport master(output in_valid, in_data, input in_ready);
    modport slave(input in_valid, in_data, output in_ready);
endinterface

// File: rtl/mini_cpu_loader.sv
// mini_cpu_loader: parses byte command frames into IMEM/regfile writes and CPU run control
module mini_cpu_loader #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic                     clk,
    input  logic                     rst,
    mini_cpu_loader_if.slave         bus,
    input  logic                     halt,
    output logic                     imem_we,
    output logic [7:0]               imem_addr,
    output logic [15:0]              imem_wdata,
    output logic                     rf_we,
    output logic [1:0]               rf_addr,
    output logic [7:0]               rf_wdata,
    output logic                     cpu_en,
    output logic                     done,
    output logic                     busy,
    output logic                     err_cmd,
    output logic                     err_timeout
);
    typedef enum logic [3:0] {
        IDLE, I_ADDR, I_HI, I_LO, R_ADDR, R_DATA, B_ADDR, B_CNT, B_HI, B_LO, RUN
    } state_t;
    state_t state, state_n;
    logic [7:0] addr, addr_n, hi, hi_n, cnt, cnt_n, d;
    logic [15:0] cyc, cyc_n, imem_wdata_n;
    logic [7:0] imem_addr_n, rf_wdata_n;
    logic [1:0] rf_addr_n;
    logic imem_we_n, rf_we_n, done_n, err_cmd_n, err_timeout_n, acc;
    assign bus.in_ready = state != RUN;
    assign cpu_en = state == RUN;
    assign busy = state != IDLE;
    assign acc = bus.in_valid && bus.in_ready;
    assign d = bus.in_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            hi          <= '0;
            cnt         <= '0;
            cyc         <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            rf_wdata    <= '0;
            done        <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            hi          <= hi_n;
            cnt         <= cnt_n;
            cyc         <= cyc_n;
            imem_we     <= imem_we_n;
            imem_addr   <= imem_addr_n;
            imem_wdata  <= imem_wdata_n;
            rf_we       <= rf_we_n;
            rf_addr     <= rf_addr_n;
            rf_wdata    <= rf_wdata_n;
            done        <= done_n;
            err_cmd     <= err_cmd_n;
            err_timeout <= err_timeout_n;
        end
    end
    always_comb begin
        state_n       = state;
        addr_n        = addr;
        hi_n          = hi;
        cnt_n         = cnt;
        cyc_n         = cyc;
        imem_we_n     = 1'b0;
        imem_addr_n   = imem_addr;
        imem_wdata_n  = imem_wdata;
        rf_we_n       = 1'b0;
        rf_addr_n     = rf_addr;
        rf_wdata_n    = rf_wdata;
        done_n        = 1'b0;
        err_cmd_n     = err_cmd;
        err_timeout_n = err_timeout;
        case (state)
            IDLE: if (acc) begin
                case (d)
                    8'hA0: begin
                        err_cmd_n     = 1'b0;
                        err_timeout_n = 1'b0;
                    end
                    8'hA1: state_n = I_ADDR;
                    8'hA2: state_n = R_ADDR;
                    8'hA3: begin
                        state_n = RUN;
                        cyc_n   = '0;
                    end
                    8'hA4: state_n = B_ADDR;
                    default: err_cmd_n = 1'b1;
                endcase
            end
            I_ADDR: if (acc) begin
                addr_n  = d;
                state_n = I_HI;
            end
            I_HI: if (acc) begin
                hi_n    = d;
                state_n = I_LO;
            end
            I_LO: if (acc) begin
                imem_we_n    = 1'b1;
                imem_addr_n  = addr;
                imem_wdata_n = {hi, d};
                state_n      = IDLE;
            end
            R_ADDR: if (acc) begin
                addr_n  = d;
                state_n = R_DATA;
            end
            // address range is checked once the frame completes so a bad frame writes nothing
            R_DATA: if (acc) begin
                err_cmd_n  = err_cmd || addr[7:2] != 6'd0;
                rf_we_n    = addr[7:2] == 6'd0;
                rf_addr_n  = addr[7:2] == 6'd0 ? addr[1:0] : rf_addr;
                rf_wdata_n = addr[7:2] == 6'd0 ? d : rf_wdata;
                state_n    = IDLE;
            end
            B_ADDR: if (acc) begin
                addr_n  = d;
                state_n = B_CNT;
            end
            B_CNT: if (acc) begin
                cnt_n   = d;
                state_n = d == 8'd0 ? IDLE : B_HI;
            end
            B_HI: if (acc) begin
                hi_n    = d;
                state_n = B_LO;
            end
            B_LO: if (acc) begin
                imem_we_n    = 1'b1;
                imem_addr_n  = addr;
                imem_wdata_n = {hi, d};
                addr_n       = addr + 8'd1;
                cnt_n        = cnt - 8'd1;
                state_n      = cnt == 8'd1 ? IDLE : B_HI;
            end
            RUN: begin
                cyc_n = cyc + 16'd1;
                // halt wins over a timeout landing on the same edge
                if (halt || (TIMEOUT != 16'd0 && cyc == TIMEOUT - 16'd1)) begin
                    done_n        = 1'b1;
                    err_timeout_n = err_timeout || !halt;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mini_cpu_loader.sv
// tb_mini_cpu_loader: directed frame vectors with hand-computed expectations
module tb_mini_cpu_loader;
    logic clk, rst, halt;
    logic imem_we, rf_we, cpu_en, done, busy, err_cmd, err_timeout;
    logic [7:0] imem_addr, rf_wdata;
    logic [15:0] imem_wdata;
    logic [1:0] rf_addr;
    int checks = 0, errors = 0, cycnt = 0, nw = 0, n_en = 0, n_done = 0, n_bad = 0;
    logic [7:0] wa [0:31];
    logic [15:0] wd [0:31];
    int wt [0:31];
    mini_cpu_loader_if bus();
    mini_cpu_loader #(.TIMEOUT(16'd8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .halt(halt),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cpu_en(cpu_en), .done(done), .busy(busy),
        .err_cmd(err_cmd), .err_timeout(err_timeout)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycnt <= cycnt + 1;
    always @(negedge clk) begin
        if (imem_we && nw < 32) begin
            wa[nw] = imem_addr;
            wd[nw] = imem_wdata;
            wt[nw] = cycnt;
            nw = nw + 1;
        end
        if (cpu_en) n_en = n_en + 1;
        if (done) n_done = n_done + 1;
        if (cpu_en && bus.in_ready) n_bad = n_bad + 1;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    function automatic logic [41:0] outs();
        return {imem_we, imem_addr, imem_wdata, rf_we, rf_addr, rf_wdata,
                cpu_en, done, busy, err_cmd, err_timeout, bus.in_ready};
    endfunction
    initial begin
        int n0, e0, d0, b0;
        bit seen;
        rst = 1'b1;
        halt = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        @(negedge clk);
        check("reset_outs", outs(), 42'h1);
        rst = 1'b0;
        // single IMEM write
        send(8'hA1); send(8'h10); send(8'h12); send(8'h34);
        @(negedge clk);
        check("imem_we", imem_we, 1);
        check("imem_addr", imem_addr, 8'h10);
        check("imem_wdata", imem_wdata, 16'h1234);
        check("imem_ready", bus.in_ready, 1);
        @(negedge clk);
        check("imem_we_once", imem_we, 0);
        // RF writes, bad address, clear
        send(8'hA2); send(8'h03); send(8'h5A);
        @(negedge clk);
        check("rf_we", rf_we, 1);
        check("rf_addr", rf_addr, 2'd3);
        check("rf_wdata", rf_wdata, 8'h5A);
        send(8'hA2); send(8'h04); send(8'h77);
        @(negedge clk);
        check("rf_bad_we", rf_we, 0);
        check("rf_bad_err", err_cmd, 1);
        check("rf_bad_keep", rf_wdata, 8'h5A);
        send(8'hA0);
        @(negedge clk);
        check("clear_err", err_cmd, 0);
        // burst wrapping FE->FF->00 at full rate
        #1 n0 = nw;
        send(8'hA4); send(8'hFE); send(8'h03);
        send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h03);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("burst_n", nw - n0, 3);
        check("burst_a0", wa[n0], 8'hFE);
        check("burst_a1", wa[n0+1], 8'hFF);
        check("burst_a2", wa[n0+2], 8'h00);
        check("burst_d0", wd[n0], 16'h0001);
        check("burst_d1", wd[n0+1], 16'h0002);
        check("burst_d2", wd[n0+2], 16'h0003);
        check("burst_gap1", wt[n0+1] - wt[n0], 2);
        check("burst_gap2", wt[n0+2] - wt[n0+1], 2);
        n0 = nw;
        send(8'hA4); send(8'h20); send(8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("burst0_n", nw - n0, 0);
        check("burst0_idle", busy, 0);
        // RUN ended by halt after 6 enabled cycles
        e0 = n_en; d0 = n_done; b0 = n_bad;
        send(8'hA3);
        repeat (6) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        check("halt_done", done, 1);
        check("halt_cpu_en", cpu_en, 0);
        halt = 1'b0;
        @(negedge clk);
        #1;
        check("halt_en_cycles", n_en - e0, 6);
        check("halt_done_cnt", n_done - d0, 1);
        check("halt_ready_low", n_bad - b0, 0);
        check("halt_no_tmo", err_timeout, 0);
        check("halt_ready_back", bus.in_ready, 1);
        // RUN ended by timeout
        e0 = n_en; d0 = n_done;
        send(8'hA3);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check("tmo_done_seen", seen, 1);
        check("tmo_err", err_timeout, 1);
        check("tmo_cpu_en", cpu_en, 0);
        @(negedge clk);
        #1;
        check("tmo_en_cycles", n_en - e0, 8);
        check("tmo_done_cnt", n_done - d0, 1);
        send(8'hA0);
        @(negedge clk);
        check("tmo_clear", err_timeout, 0);
        // halt coincides with the timeout edge
        e0 = n_en;
        send(8'hA3);
        repeat (8) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        check("both_done", done, 1);
        check("both_no_tmo", err_timeout, 0);
        halt = 1'b0;
        #1;
        check("both_en_cycles", n_en - e0, 8);
        // async reset mid-burst
        n0 = nw;
        send(8'hA4); send(8'h00); send(8'h02); send(8'hAB);
        #2 rst = 1'b1;
        #1;
        check("rst_async", outs(), 42'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_no_write", nw - n0, 0);
        check("rst_idle", outs(), 42'h1);
        send(8'h55);
        @(negedge clk);
        check("bad_op_err", err_cmd, 1);
        check("bad_op_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mini_cpu_loader.md
# mini_cpu_loader

Byte-stream loader that sits in front of the mini CPU and drives its IMEM init port, regfile init port and run enable. It parses command frames arriving on a valid/ready byte interface, from a UART receiver or a testbench, and issues single-cycle IMEM or regfile writes. It also supports auto-incrementing IMEM bursts. On a RUN command it enables the CPU until `halt` or a cycle timeout, then returns to idle.

## Interface
- `TIMEOUT`, default 1000: maximum RUN cycles before forced stop; 0 disables the timeout; 16-bit range.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: source byte valid.
- `in_data  in  8`: source byte.
- `in_ready  out  1`: loader accepts a byte this cycle.
- `halt  in  1`: CPU halt status.
- `imem_we  out  1`: IMEM write strobe.
- `imem_addr  out  8`: IMEM write address.
- `imem_wdata  out  16`: IMEM write data.
- `rf_we  out  1`: regfile write strobe.
- `rf_addr  out  2`: regfile write address.
- `rf_wdata  out  8`: regfile write data.
- `cpu_en  out  1`: CPU run enable.
- `done  out  1`: one-cycle pulse when RUN ends, by halt or by timeout.
- `busy  out  1`: high whenever the state is not IDLE.
- `err_cmd  out  1`: sticky flag for an unknown opcode or a bad regfile address.
- `err_timeout  out  1`: sticky flag set when RUN is ended by timeout.

## Operation
- A byte is accepted on a rising edge with `in_valid && in_ready`. `in_ready` is 1 in every state except RUN.
- Opcodes, taken as the first byte of a frame in IDLE:
  - 0xA0 CLEAR: clears `err_cmd` and `err_timeout`; stays in IDLE.
  - 0xA1 IMEM write: frame is addr, data_hi, data_lo. Issues one write of {hi,lo} to addr.
  - 0xA2 RF write: frame is addr, data. If addr[7:2] != 0, set `err_cmd` and perform no write. Otherwise write data to addr[1:0].
  - 0xA4 IMEM burst: frame is addr, count N, then N×(hi,lo).
    - Word k is written to (addr+k) mod 256; the address wraps 0xFF→0x00.
    - N=0 returns to IDLE after the count byte with no write.
  - 0xA3 RUN: enter RUN.
  - Any other opcode: set `err_cmd`, drop the byte, stay in IDLE.
- States: IDLE, I_ADDR, I_HI, I_LO, R_ADDR, R_DATA, B_ADDR, B_CNT, B_HI, B_LO, RUN.
  - Each state advances only on an accepted byte.
  - B_LO returns to B_HI while words remain, otherwise to IDLE.
- RUN behaviour:
  - `cpu_en` is 1 and a 16-bit cycle counter starts at 0.
  - Exit on the first edge where `halt`=1.
  - Otherwise exit when the counter reaches TIMEOUT-1 (TIMEOUT≠0); this also sets `err_timeout`.
  - Halt and timeout on the same edge count as halt; `err_timeout` is not set.
  - On exit: `cpu_en` goes to 0, `done` pulses, state returns to IDLE.
- Write strobes are registered.
  - `*_we` is high for exactly one cycle.
  - `*_addr` and `*_wdata` stay stable until the next write of the same port.
- No frame timeout: a partial frame waits indefinitely.

## Timing
- Reset values: every output is 0 except `in_ready`=1; state is IDLE; counters are 0. Reset takes effect immediately and asynchronously, including mid-frame or mid-RUN: `cpu_en` drops at once and pending writes are discarded.
- IMEM and regfile write latency:
  - `imem_we` is high in the cycle after the data_lo byte is accepted.
  - `rf_we` is high in the cycle after the data byte is accepted.
- Burst throughput: back-to-back bytes sustain one word per 2 cycles with no stalls. Consecutive `imem_we` pulses are therefore 2 cycles apart at full rate.
- RUN timing:
  - `cpu_en` rises in the cycle after 0xA3 is accepted.
  - With halt already high on entry, `cpu_en` is high for exactly 1 cycle.
  - The `done` pulse coincides with the first cycle of `cpu_en`=0.
  - A new opcode may be accepted in that same cycle.
- `err_cmd` and `err_timeout` assert in the cycle after the triggering byte or event.

## Test plan
- IMEM write: bytes A1,10,12,34 -> one `imem_we` pulse with addr 0x10, wdata 0x1234, one cycle after the last byte; `in_ready` stays 1 throughout.
- RF writes: A2,03,5A -> `rf_we` pulse with addr 3, data 0x5A. Then A2,04,77 -> no `rf_we`, `err_cmd`=1. Then A0 -> `err_cmd`=0.
- Burst with wrap: A4,FE,03 followed by three word pairs 0001, 0002, 0003 -> writes to FE, FF, 00 with data 0001, 0002, 0003, `imem_we` pulses 2 cycles apart. A4,20,00 -> no writes, back in IDLE.
- RUN with halt: A3, then `halt` raised 5 cycles later -> `cpu_en` high for 6 cycles, `done` one pulse, `in_ready` 0 during RUN, `err_timeout`=0.
- Timeout: TIMEOUT=8, A3, `halt` held 0 -> `cpu_en` high for exactly 8 cycles, `err_timeout`=1, `done` pulse. Also check the halt-and-timeout-on-same-edge case -> `err_timeout` stays 0.
- Reset and bad opcode: assert `rst` after A4,00,02,AB -> no write, all outputs at reset values. Then byte 0x55 -> `err_cmd`=1, state stays IDLE.
